// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
// Module      : dcache_responder
// Description : Direct-mapped, one-word-per-line, write-through, no-write-
//               allocate data cache responder. Loads hit in one cycle; load
//               misses and all stores go to memory through a valid/ready
//               request channel while the core is stalled.
//               Optional build macro: DCACHE_UNCACHED_REGION_EN makes the
//               region addr[31:30] == 2'b10 uncacheable.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_responder #(
  parameter int LINES = 64,
  parameter int IDXW  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int c_TAGW = 30 - IDXW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_t;

  state_t            r_state;
  logic [31:0]       r_data [LINES];
  logic [c_TAGW-1:0] r_tag  [LINES];
  logic [LINES-1:0]  r_valid;

  // Where an outstanding read miss will be installed when the fill returns
  logic [IDXW-1:0]   r_fill_idx;
  logic [c_TAGW-1:0] r_fill_tag;
  logic              r_fill_cacheable;

  logic [IDXW-1:0]   w_idx;
  logic [c_TAGW-1:0] w_tag;
  logic              w_cacheable;
  logic              w_store;
  logic              w_accept;
  logic              w_hit;
  logic              w_fill;
  logic [31:0]       w_merged;
  logic              w_unused_lsbs;

  assign w_idx         = dcache_addr[IDXW+1:2];
  assign w_tag         = dcache_addr[31:IDXW+2];
  assign w_unused_lsbs = ^dcache_addr[1:0];

`ifdef DCACHE_UNCACHED_REGION_EN
  assign w_cacheable = (dcache_addr[31:30] != 2'b10);
`else
  assign w_cacheable = 1'b1;
`endif

  // A store takes priority over a load when both are requested
  assign w_store  = |dcache_we;
  assign w_accept = (r_state == ST_IDLE) && (dcache_re || w_store);
  assign w_hit    = w_cacheable && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill   = (r_state == ST_RD_WAIT) && mem_resp_valid && r_fill_cacheable;

  // Line word with the enabled store byte lanes overlaid
  always_comb begin
    w_merged = r_data[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (dcache_we[i]) begin
        w_merged[8*i +: 8] = dcache_din[8*i +: 8];
      end
    end
  end

  // Line storage: store-hit merge at acceptance, or install on read fill
  always_ff @(posedge clk) begin
    if (w_accept && w_store && w_hit) begin
      r_data[w_idx] <= w_merged;
    end else if (w_fill) begin
      r_data[r_fill_idx] <= mem_resp_data;
      r_tag[r_fill_idx]  <= r_fill_tag;
    end
  end

  // Control FSM with registered core and memory-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_valid          <= '0;
      r_fill_idx       <= '0;
      r_fill_tag       <= '0;
      r_fill_cacheable <= 1'b0;
      stall            <= 1'b0;
      dcache_dout      <= 32'd0;
      mem_req_valid    <= 1'b0;
      mem_req_rw       <= 1'b0;
      mem_req_addr     <= 32'd0;
      mem_req_data     <= 32'd0;
      mem_req_mask     <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_store) begin
              // Write-through: every store goes to memory, hit or miss
              r_state       <= ST_WR_REQ;
              stall         <= 1'b1;
              mem_req_valid <= 1'b1;
              mem_req_rw    <= 1'b1;
              mem_req_addr  <= {dcache_addr[31:2], 2'b00};
              mem_req_data  <= dcache_din;
              mem_req_mask  <= dcache_we;
            end else if (w_hit) begin
              dcache_dout <= r_data[w_idx];
            end else begin
              r_state          <= ST_RD_REQ;
              stall            <= 1'b1;
              mem_req_valid    <= 1'b1;
              mem_req_rw       <= 1'b0;
              mem_req_addr     <= {dcache_addr[31:2], 2'b00};
              mem_req_mask     <= 4'd0;
              r_fill_idx       <= w_idx;
              r_fill_tag       <= w_tag;
              r_fill_cacheable <= w_cacheable;
            end
          end
        end
        ST_RD_REQ: begin
          if (mem_req_ready) begin
            r_state       <= ST_RD_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (mem_resp_valid) begin
            r_state     <= ST_IDLE;
            stall       <= 1'b0;
            dcache_dout <= mem_resp_data;
            if (r_fill_cacheable) begin
              r_valid[r_fill_idx] <= 1'b1;
            end
          end
        end
        ST_WR_REQ: begin
          if (mem_req_ready) begin
            r_state       <= ST_IDLE;
            stall         <= 1'b0;
            mem_req_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_responder
// Description : Randomized scoreboard bench for dcache_responder with a
//               behavioural cache/memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_responder;

  localparam int LINES = 64;
  localparam int IDXW  = 6;
`ifdef DCACHE_UNCACHED_REGION_EN
  localparam bit UNC_EN = 1'b1;
`else
  localparam bit UNC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dcache_addr = 32'd0;
  logic        dcache_re = 1'b0;
  logic [3:0]  dcache_we = 4'd0;
  logic [31:0] dcache_din = 32'd0;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  dcache_responder #(.LINES(LINES), .IDXW(IDXW)) dut (
    .clk            (clk),
    .reset          (reset),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  int total = 0;
  int bad   = 0;

  req_t        q_req[$];
  logic [31:0] q_load[$];

  // Reference model: memory image plus which tag each line holds
  logic [31:0] mem [logic [29:0]];
  bit          mvalid [LINES];
  logic [31:0] mtag   [LINES];

  // Memory responder controls
  int ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int resp_delay = 0;   // 0 = random 1..4
  bit junk_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cacheable(input logic [31:0] a);
    return !(UNC_EN && (a[31:30] == 2'b10));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return base ^ 32'h5EED_0000 ^ (base << 9);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = 32'd0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (stall) begin
      next_cycle();
      n++;
      if (n > 300) begin
        total++;
        bad++;
        $display("FAIL idle_timeout: stall still %b after %0d cycles", stall, n);
        return;
      end
    end
  endtask

  // Issue one core request; called at posedge+1. While the DUT stalls,
  // junk requests are presented that must be ignored.
  task automatic do_req(input logic [31:0] a, input logic re, input logic [3:0] we,
                        input logic [31:0] din);
    int          n;
    int          idx;
    logic [31:0] tag;
    logic [31:0] w;
    req_t        r;
    n = 0;
    while (stall) begin
      dcache_addr = $urandom;
      dcache_re   = 1'($urandom_range(0, 1));
      dcache_we   = 4'($urandom_range(0, 15));
      dcache_din  = $urandom;
      next_cycle();
      n++;
      if (n > 300) begin
        total++;
        bad++;
        $display("FAIL req_timeout: stall still %b after %0d cycles", stall, n);
        dcache_re = 1'b0;
        dcache_we = 4'd0;
        return;
      end
    end
    dcache_addr = a;
    dcache_re   = re;
    dcache_we   = we;
    dcache_din  = din;
    idx = int'((a / 4) % LINES);
    tag = a / 32'(4 * LINES);
    if (we != 4'd0) begin
      r.rw = 1'b1; r.addr = {a[31:2], 2'b00}; r.data = din; r.mask = we;
      q_req.push_back(r);
      w = mem_word(a);
      for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = din[8*i +: 8];
      mem[a[31:2]] = w;
    end else begin
      if (!(cacheable(a) && mvalid[idx] && (mtag[idx] == tag))) begin
        r.rw = 1'b0; r.addr = {a[31:2], 2'b00}; r.data = 32'd0; r.mask = 4'd0;
        q_req.push_back(r);
        if (cacheable(a)) begin
          mvalid[idx] = 1'b1;
          mtag[idx]   = tag;
        end
      end
      q_load.push_back(mem_word(a));
    end
    next_cycle();
    dcache_re = 1'b0;
    dcache_we = 4'd0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] bases [4];
    bases[0] = 32'h0000_1000;
    bases[1] = 32'h0000_1100;
    bases[2] = 32'h8000_0000;
    bases[3] = 32'h4000_0100;
    return bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
  endfunction

  // Monitor state
  bit          pend_load = 1'b0;
  logic [31:0] last_dout = 32'd0;
  bit          prev_wait = 1'b0;
  req_t        prev_req;
  req_t        exp_req;

  // Monitor: pops expectations whenever the DUT completes a load or
  // hands a request to memory; also checks request stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend_load = 1'b0;
        last_dout = 32'd0;
        prev_wait = 1'b0;
        q_load.delete();
        q_req.delete();
        continue;
      end
      if (pend_load && !stall) begin
        if (q_load.size() == 0) begin
          total++;
          bad++;
          $display("FAIL load_unexpected: dout %h with no expected load", dcache_dout);
        end else begin
          last_dout = q_load.pop_front();
        end
        check("load_data", dcache_dout, last_dout);
        pend_load = 1'b0;
      end else begin
        check("dout_hold", dcache_dout, last_dout);
      end
      if (!stall && dcache_re && (dcache_we == 4'd0)) pend_load = 1'b1;

      if (prev_wait) begin
        check("req_valid_held", 32'(mem_req_valid), 32'd1);
        check("req_rw_held",    32'(mem_req_rw),    32'(prev_req.rw));
        check("req_addr_held",  mem_req_addr,       prev_req.addr);
        check("req_data_held",  mem_req_data,       prev_req.data);
        check("req_mask_held",  32'(mem_req_mask),  32'(prev_req.mask));
      end
      prev_wait     = mem_req_valid && !mem_req_ready;
      prev_req.rw   = mem_req_rw;
      prev_req.addr = mem_req_addr;
      prev_req.data = mem_req_data;
      prev_req.mask = mem_req_mask;

      if (mem_req_valid && mem_req_ready) begin
        if (q_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_mem_req: rw=%b addr=%h, none expected", mem_req_rw, mem_req_addr);
        end else begin
          exp_req = q_req.pop_front();
          check("req_rw",   32'(mem_req_rw), 32'(exp_req.rw));
          check("req_addr", mem_req_addr,    exp_req.addr);
          if (exp_req.rw) begin
            check("req_data", mem_req_data,       exp_req.data);
            check("req_mask", 32'(mem_req_mask),  32'(exp_req.mask));
          end
        end
      end
    end
  end

  // Memory model: ready pattern, read responses after a delay, and
  // stray responses when no read is outstanding.
  bit          hs_rd = 1'b0;
  logic [31:0] hs_addr = 32'd0;
  logic [31:0] rd_addr = 32'd0;
  int          resp_cnt = 0;

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      hs_rd   = mem_req_valid && mem_req_ready && !mem_req_rw;
      hs_addr = mem_req_addr;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (hs_rd) begin
        rd_addr  = hs_addr;
        resp_cnt = (resp_delay != 0) ? resp_delay : int'($urandom_range(1, 4));
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_word(rd_addr);
        end
      end else if (junk_en && ($urandom_range(0, 7) == 0)) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
      end
      case (ready_mode)
        0:       mem_req_ready = ($urandom_range(0, 3) != 0);
        1:       mem_req_ready = 1'b1;
        default: mem_req_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int k;
    logic [31:0] a;
    clear_model();
    reset = 1'b0;
    repeat (3) next_cycle();
    check("rst_stall",     32'(stall),         32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_rw",    32'(mem_req_rw),    32'd0);
    check("rst_req_addr",  mem_req_addr,       32'd0);
    check("rst_req_data",  mem_req_data,       32'd0);
    check("rst_req_mask",  32'(mem_req_mask),  32'd0);
    check("rst_dout",      dcache_dout,        32'd0);
    reset = 1'b1;

    // Cold load miss, then immediate hit
    mem[32'h0000_1004 >> 2] = 32'hDEAD_BEEF;
    ready_mode = 1;
    resp_delay = 3;
    do_req(32'h0000_1004, 1'b1, 4'd0, 32'd0);
    do_req(32'h0000_1004, 1'b1, 4'd0, 32'd0);

    // Partial store hit with ready held low, then reload
    wait_idle();
    ready_mode = 2;
    do_req(32'h0000_1004, 1'b0, 4'b0011, 32'h0000_1234);
    repeat (2) next_cycle();
    ready_mode = 1;
    do_req(32'h0000_1004, 1'b1, 4'd0, 32'd0);

    // Same index, different tag: evicts and forces a re-miss
    do_req(32'h0000_1104, 1'b1, 4'd0, 32'd0);
    do_req(32'h0000_1004, 1'b1, 4'd0, 32'd0);

    // Reset while waiting for a fill; the late response must be dropped
    resp_delay = 6;
    do_req(32'h0000_2008, 1'b1, 4'd0, 32'd0);
    k = 0;
    while (mem_req_valid && k < 50) begin
      next_cycle();
      k++;
    end
    check("rd_wait_stall", 32'(stall), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_stall",     32'(stall),         32'd0);
    check("async_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("async_rst_dout",      dcache_dout,        32'd0);
    clear_model();
    next_cycle();
    reset = 1'b1;
    repeat (12) next_cycle();
    check("post_rst_stall", 32'(stall), 32'd0);
    resp_delay = 0;
    do_req(32'h0000_1004, 1'b1, 4'd0, 32'd0);

    // Region 0x8000_0000 twice: cached or not depending on build
    do_req(32'h8000_0000, 1'b1, 4'd0, 32'd0);
    do_req(32'h8000_0000, 1'b1, 4'd0, 32'd0);

    // Randomized traffic
    ready_mode = 0;
    junk_en    = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a = pick_addr();
      k = int'($urandom_range(0, 9));
      if (k < 5)      do_req(a, 1'b1, 4'd0, $urandom);
      else if (k < 9) do_req(a, 1'b0, 4'($urandom_range(1, 15)), $urandom);
      else            do_req(a, 1'b1, 4'($urandom_range(1, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) next_cycle();
    end

    junk_en    = 1'b0;
    ready_mode = 1;
    wait_idle();
    repeat (10) next_cycle();
    check("req_queue_drained",  32'(q_req.size()),  32'd0);
    check("load_queue_drained", 32'(q_load.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
- REQ-001: Parameter LINES, default 64, SHALL be the number of one-word direct-mapped lines and a power of two ≥ 2.
- REQ-002: Parameter IDXW, default 6, SHALL be the index width and equal log2(LINES).
- REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  SHALL be the asynchronous, active-low reset.
- REQ-005: dcache_addr  input  32  SHALL be the core byte address; bits [1:0] are ignored.
- REQ-006: dcache_re  input  1  SHALL be the core load request.
- REQ-007: dcache_we  input  4  SHALL be the core byte-lane store enables; lane i covers bits [8i+7:8i].
- REQ-008: dcache_din  input  32  SHALL be the core store data.
- REQ-009: dcache_dout  output  32  SHALL be the load data.
- REQ-010: stall  output  1  SHALL indicate that the core must hold the pipeline.
- REQ-011: mem_req_valid/mem_req_ready  output/input  1/1  SHALL be the memory request handshake.
- REQ-012: mem_req_rw  output  1  SHALL select the request type: 1 = write, 0 = read.
- REQ-013: mem_req_addr  output  32  SHALL be the word-aligned request address.
- REQ-014: mem_req_data  output  32  SHALL be the write data.
- REQ-015: mem_req_mask  output  4  SHALL be the byte-lane write mask.
- REQ-016: mem_resp_valid/mem_resp_data  input  1/32  SHALL be the memory read response.

Function
- REQ-017: The block SHALL accept a request in any cycle where stall=0 and (dcache_re=1 or dcache_we≠0), capturing the address, enables and data.
- REQ-018: When dcache_we≠0, the block SHALL treat the request as a store and ignore dcache_re.
- REQ-019: Lookup SHALL use index = addr[IDXW+1:2] and tag = addr[31:IDXW+2], with one valid bit per line.
- REQ-020: On a load hit, the block SHALL drive dcache_dout with the line word in the cycle after acceptance, with stall=0 (1-cycle latency).
- REQ-021: The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT and WR_REQ.
- REQ-022: On a load miss, the block SHALL go IDLE→RD_REQ, assert stall from the next cycle and drive mem_req_valid=1, rw=0.
- REQ-023: On a load miss, the block SHALL move RD_REQ→RD_WAIT on valid&&ready.
- REQ-024: On mem_resp_valid in RD_WAIT, the block SHALL install the data, set valid and return to IDLE.
- REQ-025: In the cycle after mem_resp_valid, the block SHALL drive stall=0 and dcache_dout = the fill data.
- REQ-026: Every store SHALL be write-through: IDLE→WR_REQ, stall=1 from the next cycle, and mem_req_valid=1 with rw=1, mask = dcache_we, and data = din.
- REQ-027: A store SHALL return to IDLE on valid&&ready, with stall=0 in the following cycle.
- REQ-028: On a store hit, the block SHALL merge the enabled byte lanes into the line at acceptance.
- REQ-029: On a store miss, the block SHALL NOT allocate a line.
- REQ-030: mem_req_addr, data, mask and rw SHALL be held stable while mem_req_valid=1 and ready=0.
- REQ-031: mem_req_valid SHALL NOT drop before acceptance.
- REQ-032: While stall=1, new core requests SHALL be ignored.
- REQ-033: Requests accepted on back-to-back cycles SHALL each be serviced; a hit immediately after a fill SHALL see the fill.
- REQ-034: mem_resp_valid outside RD_WAIT SHALL be discarded.
- REQ-035: dcache_dout SHALL hold its last value when no load completes.
- REQ-036: Two addresses with the same index and different tags SHALL replace each other (the later fill wins).

Reset
- REQ-037: On reset low, the block SHALL immediately force FSM=IDLE, clear all valid bits, and drive stall=0, mem_req_valid=0, and dcache_dout, mem_req_addr, mem_req_data and mem_req_mask to 0, with mem_req_rw=0.
- REQ-038: Reset asserted mid-transaction SHALL abandon the transaction; line data contents are don't-care after reset.
- REQ-039: The block SHALL accept requests from the first rising edge after reset deasserts.

Configuration
- REQ-040: With macro DCACHE_UNCACHED_REGION_EN defined, loads with addr[31:30]=2'b10 SHALL always take the miss path without installing a line.
- REQ-041: With DCACHE_UNCACHED_REGION_EN defined, stores with addr[31:30]=2'b10 SHALL never update a line.
- REQ-042: Without DCACHE_UNCACHED_REGION_EN, all addresses SHALL be cacheable.

Verification
- REQ-043: Load 0x0000_1004 after reset, memory returns 0xDEADBEEF after 3 cycles -> one rd request to addr 0x0000_1004; stall=0 and dout=0xDEADBEEF the cycle after the response.
- REQ-044: Immediate reload of 0x0000_1004 -> no memory request; dout=0xDEADBEEF next cycle; stall stays 0.
- REQ-045: Store we=4'b0011, din=0x0000_1234 to 0x0000_1004, with ready low 2 cycles -> rw=1, mask=0011 stable across the wait; a later load returns 0xDEAD1234 with no miss.
- REQ-046: Load 0x0000_1104 (same index, new tag) -> miss; a subsequent load of 0x0000_1004 misses again.
- REQ-047: Reset pulled low during RD_WAIT, then a response arrives -> response discarded, stall=0, and a load of 0x0000_1004 misses.
- REQ-048: With DCACHE_UNCACHED_REGION_EN, two loads of 0x8000_0000 -> two memory read requests.
